// File: rtl/bathroom_pkg.sv
// -----------------------------------------------------------------------------
// bathroom_pkg
//   Shared definitions for the bathroom panel keypad scanner.
//   - key_state_t : debounce FSM state encoding
//   - KEY_*       : key codes that mode control maps to functions
//   - first_low_col() : picks the lowest active (low) column of a row sample
// -----------------------------------------------------------------------------
package bathroom_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } key_state_t;

  // Key codes are {row[1:0], col[1:0]}.
  localparam logic [3:0] KEY_VENT = 4'h0;
  localparam logic [3:0] KEY_WARM = 4'h1;
  localparam logic [3:0] KEY_HOT  = 4'h2;
  localparam logic [3:0] KEY_DRY  = 4'h3;
  localparam logic [3:0] KEY_STOP = 4'hF;

  // Columns are active-low; lowest index wins so the final code is row-major lowest.
  function automatic logic [1:0] first_low_col(input logic [3:0] col);
    logic [1:0] idx;
    if (!col[0]) begin
      idx = 2'd0;
    end else if (!col[1]) begin
      idx = 2'd1;
    end else if (!col[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/row_scan_timer.sv
// -----------------------------------------------------------------------------
// row_scan_timer
//   Drives the keypad rows one at a time, ROW_DWELL cycles each, and tells the
//   parent when to sample the columns.
//   Ports:
//     s_clk     in   scan clock
//     rst       in   synchronous active-high reset
//     key_row   out  active-low one-hot row drive (registered)
//     row_idx   out  index of the row currently driven
//     sample    out  last dwell cycle of the current row (columns settled)
//     scan_done out  sample of row 3, i.e. end of a full scan (1-cycle pulse)
// -----------------------------------------------------------------------------
module row_scan_timer #(
  parameter int ROW_DWELL = 1000
) (
  input  logic       s_clk,
  input  logic       rst,
  output logic [3:0] key_row,
  output logic [1:0] row_idx,
  output logic       sample,
  output logic       scan_done
);

  localparam int DW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0] DWELL_ZERO = DW'(0);

  logic [DW-1:0] dwell_cnt_r;
  logic [1:0]    row_idx_r;
  logic [3:0]    key_row_r;
  logic          sample_s;

  assign sample_s  = (dwell_cnt_r == DWELL_LAST);
  assign sample    = sample_s;
  assign scan_done = sample_s && (row_idx_r == 2'd3);
  assign row_idx   = row_idx_r;
  assign key_row   = key_row_r;

  // Dwell counter, row index and row drive advance together after each sample.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      dwell_cnt_r <= DWELL_ZERO;
      row_idx_r   <= 2'd0;
      key_row_r   <= 4'b1110;
    end else if (sample_s) begin
      dwell_cnt_r <= DWELL_ZERO;
      row_idx_r   <= row_idx_r + 2'd1;
      // Rotating the single low bit keeps key_row in step with row_idx.
      key_row_r   <= {key_row_r[2:0], key_row_r[3]};
    end else begin
      dwell_cnt_r <= dwell_cnt_r + DWELL_ONE;
      row_idx_r   <= row_idx_r;
      key_row_r   <= key_row_r;
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// -----------------------------------------------------------------------------
// key_matrix_scan
//   4x4 panel keypad scanner: drives rows, reads columns, debounces over whole
//   scans, encodes one key and hands it to mode control via valid/ack.
//   Optional feature: define KEY_REPEAT_EN for auto-repeat while a key is held
//   (one event every REPEAT_SCANS scans). Without it, one event per press.
//   Ports:
//     s_clk     in   1 MHz scan clock
//     rst       in   synchronous active-high reset
//     keyCol    in   column sense, active-low
//     keyAck    in   consumer accepts keyCode (1-cycle pulse)
//     keyRow    out  row drive, active-low one-hot
//     keyCode   out  {row,col} of the accepted key
//     keyValid  out  keyCode valid, held until keyAck
//     keyHeld   out  debounced key currently down
//     keyLost   out  sticky: an event was dropped; cleared by keyAck
// -----------------------------------------------------------------------------
module key_matrix_scan #(
  parameter int ROW_DWELL      = 1000,
  parameter int DEBOUNCE_SCANS = 5,
  parameter int REPEAT_SCANS   = 125
) (
  input  logic       s_clk,
  input  logic       rst,
  input  logic [3:0] keyCol,
  input  logic       keyAck,
  output logic [3:0] keyRow,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyHeld,
  output logic       keyLost
);
  import bathroom_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_SCANS);

  logic [1:0]    row_idx_s;
  logic          sample_s;
  logic          scan_done_s;
  logic          row_hit_s;
  logic [3:0]    row_code_s;
  logic          hit_acc_r;
  logic [3:0]    cand_acc_r;
  logic          snap_hit_s;
  logic [3:0]    snap_cand_s;
  key_state_t    state_r;
  key_state_t    state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic [CW-1:0] cnt_inc_s;
  logic [3:0]    cand_r;
  logic [3:0]    cand_next_s;
  logic          accept_s;
  logic          release_s;
  logic          rep_fire_s;
  logic          event_s;
  logic [3:0]    event_code_s;
  logic          slot_free_s;

  row_scan_timer #(
    .ROW_DWELL (ROW_DWELL)
  ) u_timer (
    .s_clk     (s_clk),
    .rst       (rst),
    .key_row   (keyRow),
    .row_idx   (row_idx_s),
    .sample    (sample_s),
    .scan_done (scan_done_s)
  );

  assign row_hit_s  = (keyCol != 4'hF);
  assign row_code_s = {row_idx_s, first_low_col(keyCol)};

  // Collect the first hit of the scan; rows arrive in order so the first hit is the lowest code.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      hit_acc_r  <= 1'b0;
      cand_acc_r <= 4'h0;
    end else if (sample_s) begin
      if (row_idx_s == 2'd0) begin
        hit_acc_r  <= row_hit_s;
        cand_acc_r <= row_code_s;
      end else if (!hit_acc_r && row_hit_s) begin
        hit_acc_r  <= 1'b1;
        cand_acc_r <= row_code_s;
      end else begin
        hit_acc_r  <= hit_acc_r;
        cand_acc_r <= cand_acc_r;
      end
    end else begin
      hit_acc_r  <= hit_acc_r;
      cand_acc_r <= cand_acc_r;
    end
  end

  // Row 3's sample is folded in combinationally so the FSM sees the whole scan on scan_done.
  assign snap_hit_s  = hit_acc_r | row_hit_s;
  assign snap_cand_s = hit_acc_r ? cand_acc_r : row_code_s;
  assign cnt_inc_s   = (cnt_r == CNT_FULL) ? cnt_r : (cnt_r + CNT_ONE);

  // FSM state register with its debounce counter and latched candidate.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      cand_r  <= 4'h0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      cand_r  <= cand_next_s;
    end
  end

  // FSM next state, evaluated once per full scan.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    cand_next_s  = cand_r;
    if (scan_done_s) begin
      case (state_r)
        IDLE: begin
          if (snap_hit_s) begin
            cand_next_s  = snap_cand_s;
            cnt_next_s   = CNT_ONE;
            state_next_s = (CNT_ONE == CNT_FULL) ? PRESSED : DEB_PRESS;
          end else begin
            cnt_next_s   = CNT_ZERO;
          end
        end
        DEB_PRESS: begin
          if (!snap_hit_s) begin
            state_next_s = IDLE;
            cnt_next_s   = CNT_ZERO;
          end else if (snap_cand_s == cand_r) begin
            cnt_next_s   = cnt_inc_s;
            state_next_s = (cnt_inc_s == CNT_FULL) ? PRESSED : DEB_PRESS;
          end else begin
            cand_next_s  = snap_cand_s;
            cnt_next_s   = CNT_ONE;
            state_next_s = (CNT_ONE == CNT_FULL) ? PRESSED : DEB_PRESS;
          end
        end
        PRESSED: begin
          // Any hit keeps the key down: no rollover to a second key.
          if (!snap_hit_s) begin
            cnt_next_s   = CNT_ONE;
            state_next_s = (CNT_ONE == CNT_FULL) ? IDLE : DEB_RELEASE;
          end else begin
            state_next_s = PRESSED;
          end
        end
        DEB_RELEASE: begin
          if (snap_hit_s) begin
            state_next_s = PRESSED;
            cnt_next_s   = CNT_ZERO;
          end else begin
            cnt_next_s   = cnt_inc_s;
            state_next_s = (cnt_inc_s == CNT_FULL) ? IDLE : DEB_RELEASE;
          end
        end
        default: begin
          state_next_s = IDLE;
          cnt_next_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM outputs: press accepted / release completed on this scan.
  always_comb begin
    accept_s  = 1'b0;
    release_s = 1'b0;
    if ((state_next_s == PRESSED) && ((state_r == IDLE) || (state_r == DEB_PRESS))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if ((state_next_s == IDLE) && ((state_r == PRESSED) || (state_r == DEB_RELEASE))) begin
      release_s = 1'b1;
    end else begin
      release_s = 1'b0;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_ZERO = RW'(0);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);
  localparam logic [RW-1:0] REP_FULL = RW'(REPEAT_SCANS);

  logic [RW-1:0] rep_cnt_r;
  logic [RW-1:0] rep_next_s;

  // Repeat counter counts scans spent in PRESSED; cleared whenever PRESSED is left.
  always_comb begin
    rep_next_s = rep_cnt_r;
    rep_fire_s = 1'b0;
    if (state_next_s != PRESSED) begin
      rep_next_s = REP_ZERO;
    end else if (scan_done_s && (state_r == PRESSED)) begin
      if ((rep_cnt_r + REP_ONE) == REP_FULL) begin
        rep_fire_s = 1'b1;
        rep_next_s = REP_ZERO;
      end else begin
        rep_next_s = rep_cnt_r + REP_ONE;
      end
    end else begin
      rep_next_s = rep_cnt_r;
    end
  end

  // Repeat counter register.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      rep_cnt_r <= REP_ZERO;
    end else begin
      rep_cnt_r <= rep_next_s;
    end
  end
`else
  assign rep_fire_s = 1'b0;
`endif

  assign event_s      = accept_s | rep_fire_s;
  assign event_code_s = accept_s ? snap_cand_s : keyCode;
  // An ack in the same cycle frees the slot, so a coinciding new event replaces the old one.
  assign slot_free_s  = !keyValid || keyAck;

  // Consumer-facing outputs: held flag, event slot and lost flag.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      keyCode  <= 4'h0;
      keyValid <= 1'b0;
      keyHeld  <= 1'b0;
      keyLost  <= 1'b0;
    end else begin
      if (accept_s) begin
        keyHeld <= 1'b1;
      end else if (release_s) begin
        keyHeld <= 1'b0;
      end else begin
        keyHeld <= keyHeld;
      end
      if (event_s) begin
        if (slot_free_s) begin
          keyCode  <= event_code_s;
          keyValid <= 1'b1;
          keyLost  <= 1'b0;
        end else begin
          keyLost  <= 1'b1;
        end
      end else if (keyAck && keyValid) begin
        keyValid <= 1'b0;
        keyLost  <= 1'b0;
      end else begin
        keyValid <= keyValid;
        keyLost  <= keyLost;
      end
    end
  end

endmodule
